// File: rtl/wb_pkg.sv
// Shared Wishbone definitions used by the memory responder and the SDRAM initiator side.
package wb_pkg;

    localparam int WB_ADDR_W = 25;
    localparam int WB_DATA_W = 32;
    localparam int WB_SEL_W  = 4;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    typedef enum logic [1:0] {
        WB_IDLE  = 2'd0,
        WB_WAIT  = 2'd1,
        WB_ACK   = 2'd2,
        WB_BURST = 2'd3
    } wb_state_e;

    // Plain-vector aliases of the enum for blocks that keep state in logic vectors
    localparam logic [1:0] ST_IDLE  = WB_IDLE;
    localparam logic [1:0] ST_WAIT  = WB_WAIT;
    localparam logic [1:0] ST_ACK   = WB_ACK;
    localparam logic [1:0] ST_BURST = WB_BURST;

    // Anything that is not an incrementing burst behaves as a classic cycle
    function automatic logic wb_cti_is_incr(input logic [2:0] cti);
        return cti == CTI_INCR;
    endfunction

endpackage

// File: rtl/wb_mem_slave_if.sv
// Wishbone bus bundle between an initiator and the memory responder; names follow the responder's view.
interface wb_mem_slave_if;
    import wb_pkg::*;

    logic                 wb_stb_i;
    logic                 wb_cyc_i;
    logic                 wb_we_i;
    logic [WB_ADDR_W-1:0] wb_addr_i;
    logic [WB_DATA_W-1:0] wb_dat_i;
    logic [WB_SEL_W-1:0]  wb_sel_i;
    logic [2:0]           wb_cti_i;
    logic                 wb_ack_o;
    logic [WB_DATA_W-1:0] wb_dat_o;

    modport slave (
        input  wb_stb_i, wb_cyc_i, wb_we_i, wb_addr_i, wb_dat_i, wb_sel_i, wb_cti_i,
        output wb_ack_o, wb_dat_o
    );

    modport master (
        output wb_stb_i, wb_cyc_i, wb_we_i, wb_addr_i, wb_dat_i, wb_sel_i, wb_cti_i,
        input  wb_ack_o, wb_dat_o
    );

endinterface

// File: rtl/wb_mem_bytelane_ram.sv
// Single-port word RAM built from one 8-bit array per byte lane, with a registered, clearable read port.
module wb_mem_bytelane_ram
    import wb_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic                 clk,
    input  logic [WB_SEL_W-1:0]  we_i,
    input  logic [ADDR_W-1:0]    addr_i,
    input  logic [WB_DATA_W-1:0] wdata_i,
    input  logic                 rd_en_i,
    input  logic                 rd_clr_i,
    output logic [WB_DATA_W-1:0] rdata_o
);

    localparam int DEPTH = 2 ** ADDR_W;

    for (genvar l = 0; l < WB_SEL_W; l++) begin : g_lane
        logic [7:0] mem [DEPTH];
        logic [7:0] rd_q;

        always_ff @(posedge clk) begin
            if (we_i[l]) begin
                mem[addr_i] <= wdata_i[8*l +: 8];
            end
        end

        // Read register holds between reads so the bus data stays stable
        always_ff @(posedge clk) begin
            if (rd_clr_i) begin
                rd_q <= '0;
            end else if (rd_en_i) begin
                rd_q <= mem[addr_i];
            end
        end

        assign rdata_o[8*l +: 8] = rd_q;
    end

endmodule

// File: rtl/wb_mem_slave.sv
// Wishbone responder backed by on-chip RAM: classic cycles with wait states plus zero-wait incrementing bursts.
module wb_mem_slave
    import wb_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int WAIT_STATES = 2
) (
    input  logic          clk,
    input  logic          rst,
    wb_mem_slave_if.slave wb,
    output logic          busy
);

    localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES == 0 ? 0 : WAIT_STATES - 1);

    logic [1:0]        state_q, state_d;
    logic [3:0]        wcnt_q, wcnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              req;
    logic              ack;
    logic [WB_SEL_W-1:0] lane_we;
    logic              rd_en;
    logic [ADDR_W-1:0] ram_addr;
    logic              unused_addr_hi;

    assign req = wb.wb_stb_i & wb.wb_cyc_i;

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        addr_d  = addr_q;
        ack     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    addr_d = wb.wb_addr_i[ADDR_W-1:0];
                    if (WAIT_STATES == 0) begin
                        state_d = ST_ACK;
                    end else begin
                        state_d = ST_WAIT;
                        wcnt_d  = WS_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (!req) begin
                    state_d = ST_IDLE;
                end else if (wcnt_q == '0) begin
                    state_d = ST_ACK;
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end
            ST_ACK: begin
                if (!wb.wb_cyc_i) begin
                    state_d = ST_IDLE;
                end else begin
                    ack = 1'b1;
                    if (wb.wb_stb_i && wb_cti_is_incr(wb.wb_cti_i)) begin
                        state_d = ST_BURST;
                        addr_d  = addr_q + 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_BURST: begin
                // stb low with cyc high is an initiator wait: hold without acking
                if (!wb.wb_cyc_i) begin
                    state_d = ST_IDLE;
                end else if (wb.wb_stb_i) begin
                    ack = 1'b1;
                    if (wb_cti_is_incr(wb.wb_cti_i)) begin
                        addr_d = addr_q + 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            wcnt_q  <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            addr_q  <= addr_d;
        end
    end

    // Writes land on the edge ending an acked beat; reads prefetch the next beat's word on the same edge
    assign lane_we  = (rst && ack && wb.wb_we_i) ? wb.wb_sel_i : '0;
    assign rd_en    = !wb.wb_we_i && (state_d == ST_ACK || state_d == ST_BURST);
    assign ram_addr = (ack && wb.wb_we_i) ? addr_q : addr_d;

    wb_mem_bytelane_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk      (clk),
        .we_i     (lane_we),
        .addr_i   (ram_addr),
        .wdata_i  (wb.wb_dat_i),
        .rd_en_i  (rd_en),
        .rd_clr_i (!rst),
        .rdata_o  (wb.wb_dat_o)
    );

    assign wb.wb_ack_o = ack;
    assign busy        = state_q != ST_IDLE;

    assign unused_addr_hi = ^wb.wb_addr_i[WB_ADDR_W-1:ADDR_W];

endmodule

// File: doc/wb_mem_slave.md
Name: wb_mem_slave

Overview:
- Wishbone responder (slave) with on-chip word memory. It is the target end of the Wishbone bus driven by the team's SDRAM write/read initiator.
- Stands in for the SDRAM controller during bring-up and simulation, and doubles as a small scratch RAM in the design.
- Supports classic single cycles and incrementing bursts (CTI), programmable wait states and per-byte write enables.

Parameters:
- ADDR_W, 10, word-address bits used to index memory; DEPTH = 2**ADDR_W 32-bit words.
- WAIT_STATES, 2, idle cycles inserted before the first ack of each cycle (0..15).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous reset, active-low (0 = reset)
- wb_stb_i  in  1  strobe from initiator
- wb_cyc_i  in  1  bus cycle valid
- wb_we_i  in  1  1 = write, 0 = read
- wb_addr_i  in  25  word address; only bits [ADDR_W-1:0] are decoded
- wb_dat_i  in  32  write data
- wb_sel_i  in  4  byte enables; bit n = byte n (bits 8n+7:8n)
- wb_cti_i  in  3  cycle type: 000 classic, 010 incrementing burst, 111 end-of-burst
- wb_ack_o  out  1  transfer acknowledge
- wb_dat_o  out  32  read data
- busy  out  1  high whenever the state is not IDLE

Behaviour:
- Reset (rst=0 at a clock edge):
  - wb_ack_o=0, wb_dat_o=0, busy=0, state=IDLE, wait counter=0, burst address=0.
  - Memory contents are undefined and are not cleared.
  - Reset wins over every other input, including mid-burst; a pending write is not committed.
- States:
  - IDLE, WAIT, ACK, BURST.
  - Encoding comes from the shared package.
- IDLE:
  - On stb&cyc high, latch addr[ADDR_W-1:0] into cur_addr.
  - If WAIT_STATES=0, go to ACK; otherwise go to WAIT and load the counter with WAIT_STATES-1.
- WAIT:
  - Decrement the counter each cycle; at 0, go to ACK.
- ACK:
  - wb_ack_o=1 for exactly this cycle.
  - Read: wb_dat_o = mem[cur_addr], valid in the same cycle as ack (registered, prepared on the prior edge).
  - Write: commit bytes with sel=1 at the edge ending the ACK cycle; bytes with sel=0 are unchanged.
  - Latency: ack appears WAIT_STATES+1 cycles after the cycle in which stb&cyc is first sampled high.
- After ACK:
  - If cti=010 and stb&cyc still high, go to BURST with cur_addr+1 (mod DEPTH).
  - Otherwise go to IDLE. A classic master drops stb the cycle after ack, so a lone ack pulse never double-acks.
- BURST:
  - Zero wait states: ack=1 on every cycle that stb&cyc are high, and cur_addr increments after each beat (mod DEPTH, wraps DEPTH-1 to 0).
  - A beat sampled with cti=111 is acked, then the state goes to IDLE.
  - If stb drops while cyc stays high, ack=0 and the state holds (wait by initiator).
- Abort:
  - cyc low in WAIT, ACK or BURST: ack forced 0 that cycle, no write commit, state goes to IDLE.
  - stb low with cyc high in WAIT: return to IDLE (request withdrawn).
- Between accesses:
  - wb_dat_o holds its last value between reads.
  - Writes do not change wb_dat_o.
- Illegal cti values (001, 011 to 110): treated as classic.
- Simultaneous read and write to the same address is impossible (single port); a read beat after a write beat to the same address returns the new data.
- The upper address bits [24:ADDR_W] are ignored, so addresses alias.

Decomposition:
- Package wb_pkg:
  - CTI_CLASSIC=3'b000, CTI_INCR=3'b010, CTI_EOB=3'b111.
  - State enum (IDLE/WAIT/ACK/BURST).
  - WB_ADDR_W=25, WB_DATA_W=32, WB_SEL_W=4.
  - Shared with the initiator side.
- Sub-module wb_mem_bytelane_ram:
  - Four 8-bit-wide DEPTH-entry arrays with per-lane write enable and a registered read port.
  - The top level holds the FSM, wait counter and burst address generator.

Test Plan:
- Classic write then read (WAIT_STATES=2): write 0xDEADBEEF to addr 0x005, sel=1111, then read 0x005.
  - Ack occurs 3 cycles after stb, as a single-cycle pulse.
  - Read returns 0xDEADBEEF with ack.
- Byte enables: write 0xFFFFFFFF at addr 7, then write 0x11223344 with sel=0101.
  - Read of addr 7 returns 0xFF22FF44.
- Incrementing burst:
  - Preload addr 0x3FE, 0x3FF, 0x000, 0x001 with 1, 2, 3, 4.
  - Burst read from 0x3FE, cti=010,010,010,111.
  - Expect 4 consecutive acks returning 1, 2, 3, 4 (wrap), then busy=0.
- Abort: start a write to addr 9 (data 0xA5A5A5A5), drop cyc during WAIT.
  - No ack.
  - A subsequent read of addr 9 returns the prior value.
- Reset mid-burst: drive rst=0 during beat 2 of a write burst.
  - Next cycle: ack=0, wb_dat_o=0, busy=0.
  - Beat 2 data is not written.
  - After rst=1, a classic read works with normal latency.
- WAIT_STATES=0 and alias: write 0x12345678 to addr 0x0400 (ADDR_W=10).
  - Ack occurs 1 cycle after stb.
  - Read of addr 0x000 returns 0x12345678.
